// File: rtl/reg_dumper_if.sv
// Register-file debug read port plus downstream byte stream, seen from the dumper (master) and the sink/regfile side (slave).
// Latency: reg_val is combinational for reg_addr; tx_* follows valid/ready, byte moves on tx_valid && tx_ready.
interface reg_dumper_if;
  logic [4:0]  reg_addr;
  logic [31:0] reg_val;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output reg_addr,
    output tx_data,
    output tx_valid,
    input  reg_val,
    input  tx_ready
  );

  modport slave (
    input  reg_addr,
    input  tx_data,
    input  tx_valid,
    output reg_val,
    output tx_ready
  );
endinterface

// File: rtl/reg_dumper.sv
// Streams a 130-byte frame (header, 32 big-endian registers, XOR checksum) of the register file on start.
// Latency: 162 cycles HDR-entry to checksum transfer at full rate; any tx_ready=0 holds tx_data and state frozen.
module reg_dumper #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  reg_dumper_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    CSUM,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [1:0]  byte_cnt;
  logic [31:0] shift;
  logic [7:0]  csum;
  logic        xfer;

  assign xfer = bus.tx_valid && bus.tx_ready;

  // All outputs are registered: each transition also loads the values the next state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 5'd0;
      byte_cnt     <= 2'd0;
      shift        <= 32'd0;
      csum         <= 8'd0;
      bus.reg_addr <= 5'd0;
      bus.tx_data  <= 8'd0;
      bus.tx_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR;
            idx          <= 5'd0;
            byte_cnt     <= 2'd0;
            csum         <= 8'd0;
            bus.reg_addr <= 5'd0;
            bus.tx_data  <= HEADER;
            bus.tx_valid <= 1'b1;
            busy         <= 1'b1;
          end
        end

        HDR: begin
          if (xfer) begin
            state        <= LOAD;
            csum         <= csum ^ bus.tx_data;
            bus.tx_data  <= 8'd0;
            bus.tx_valid <= 1'b0;
          end
        end

        // Only cycle in which reg_val is sampled, so later regfile writes are not seen.
        LOAD: begin
          state        <= SEND;
          shift        <= bus.reg_val;
          byte_cnt     <= 2'd0;
          bus.tx_data  <= bus.reg_val[31:24];
          bus.tx_valid <= 1'b1;
        end

        SEND: begin
          if (xfer) begin
            csum     <= csum ^ bus.tx_data;
            shift    <= shift << 8;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt != 2'd3) begin
              bus.tx_data <= shift[23:16];
            end else if (idx == 5'd31) begin
              state       <= CSUM;
              bus.tx_data <= csum ^ bus.tx_data;
            end else begin
              state        <= LOAD;
              idx          <= idx + 5'd1;
              bus.reg_addr <= idx + 5'd1;
              bus.tx_data  <= 8'd0;
              bus.tx_valid <= 1'b0;
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            state        <= DONE;
            csum         <= csum ^ bus.tx_data;
            bus.tx_data  <= 8'd0;
            bus.tx_valid <= 1'b0;
            done         <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          bus.reg_addr <= 5'd0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          bus.reg_addr <= 5'd0;
          bus.tx_data  <= 8'd0;
          bus.tx_valid <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
